gpio_code_entry: RTL and testbench

//  Player-side code entry for the code-guessing game. Three GPIO push-buttons
//  are synchronised and debounced; the block then captures three sequential

---
 rtl/gpio_code_entry.sv | 141 ++++++++++++++
 tb/tb_gpio_code_entry.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_code_entry.sv
// rtl/gpio_code_entry.sv - three-symbol code entry from debounced GPIO push-buttons
module gpio_code_entry #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [2:0] GPIO,
    input  logic       code_ack,
    output logic [1:0] a,
    output logic [1:0] b,
    output logic [1:0] c,
    output logic [1:0] num_inputs,
    output logic       code_valid,
    output logic       entry_error
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_LOAD_A, S_WAIT_A, S_LOAD_B, S_WAIT_B, S_LOAD_C, S_WAIT_C, S_DONE
    } state_t;

    logic [2:0]       sync_q, sync_d, raw_q, raw_d, raw_prev_q, raw_prev_d, deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [1:0]       a_q, a_d, b_q, b_d, c_q, c_d, num_q, num_d;
    logic             err_q, err_d;
    logic             deb_upd, press, multi;
    logic [1:0]       sym;

    always_comb begin
        sync_d     = GPIO;
        raw_d      = sync_q;
        raw_prev_d = raw_q;
        deb_d      = deb_q;
        cnt_d      = cnt_q;
        deb_upd    = 1'b0;
        if (raw_q == deb_q || raw_q != raw_prev_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            deb_d   = raw_q;
            cnt_d   = '0;
            deb_upd = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Events fire only on the debounced 000 -> non-zero transition itself.
    assign press = deb_upd && (deb_q == 3'b000) && $onehot(raw_q);
    assign multi = deb_upd && (deb_q == 3'b000) && !$onehot(raw_q);
    assign sym   = raw_q[0] ? 2'd0 : (raw_q[1] ? 2'd1 : 2'd2);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        num_d   = num_q;
        err_d   = 1'b0;
        case (state_q)
            S_LOAD_A: begin
                if (press) begin
                    a_d     = sym;
                    num_d   = num_q + 2'd1;
                    state_d = S_WAIT_A;
                end else if (multi) begin
                    err_d = 1'b1;
                end
            end
            S_WAIT_A: if (deb_q == 3'b000) state_d = S_LOAD_B;
            S_LOAD_B: begin
                if (press) begin
                    b_d     = sym;
                    num_d   = num_q + 2'd1;
                    state_d = S_WAIT_B;
                end else if (multi) begin
                    err_d = 1'b1;
                end
            end
            S_WAIT_B: if (deb_q == 3'b000) state_d = S_LOAD_C;
            S_LOAD_C: begin
                if (press) begin
                    c_d     = sym;
                    num_d   = num_q + 2'd1;
                    state_d = S_WAIT_C;
                end else if (multi) begin
                    err_d = 1'b1;
                end
            end
            S_WAIT_C: if (deb_q == 3'b000) state_d = S_DONE;
            S_DONE: begin
                if (code_ack) begin
                    a_d     = 2'd0;
                    b_d     = 2'd0;
                    c_d     = 2'd0;
                    num_d   = 2'd0;
                    state_d = S_LOAD_A;
                end
            end
            default: state_d = S_LOAD_A;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_q     <= 3'b000;
            raw_q      <= 3'b000;
            raw_prev_q <= 3'b000;
            deb_q      <= 3'b000;
            cnt_q      <= '0;
            state_q    <= S_LOAD_A;
            a_q        <= 2'd0;
            b_q        <= 2'd0;
            c_q        <= 2'd0;
            num_q      <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            raw_q      <= raw_d;
            raw_prev_q <= raw_prev_d;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            num_q      <= num_d;
            err_q      <= err_d;
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign c           = c_q;
    assign num_inputs  = num_q;
    assign code_valid  = (state_q == S_DONE);
    assign entry_error = err_q;

endmodule

// File: tb/tb_gpio_code_entry.sv
// tb/tb_gpio_code_entry.sv - randomized self-checking bench for gpio_code_entry
module tb_gpio_code_entry;

    localparam int D = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [2:0] GPIO     = 3'b000;
    logic       code_ack = 1'b0;
    logic [1:0] a, b, c, num_inputs;
    logic       code_valid, entry_error;

    int checks = 0;
    int errors = 0;
    int err_total = 0;
    int q[$];

    gpio_code_entry #(.DEBOUNCE_CYCLES(D)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .GPIO       (GPIO),
        .code_ack   (code_ack),
        .a          (a),
        .b          (b),
        .c          (c),
        .num_inputs (num_inputs),
        .code_valid (code_valid),
        .entry_error(entry_error)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) if (entry_error === 1'b1) err_total++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".a"}, a, (q.size() > 0) ? q[0] : 0);
        chk({tag, ".b"}, b, (q.size() > 1) ? q[1] : 0);
        chk({tag, ".c"}, c, (q.size() > 2) ? q[2] : 0);
        chk({tag, ".num"}, num_inputs, q.size());
        chk({tag, ".valid"}, code_valid, (q.size() == 3) ? 1 : 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        GPIO  = 3'b000;
        step(2);
        reset = 1'b0;
        q.delete();
    endtask

    task automatic bounce(input int bit_i, input int cycles);
        int t;
        t = 0;
        while (t < cycles) begin
            int p;
            p = $urandom_range(1, 2);
            GPIO[bit_i] = ~GPIO[bit_i];
            step(p);
            t += p;
        end
    endtask

    task automatic do_press(input int sym, input bit bouncy, input int hold);
        int e0;
        e0 = err_total;
        if (bouncy) bounce(sym, $urandom_range(6, 16));
        GPIO = 3'b000;
        GPIO[sym] = 1'b1;
        step(hold);
        if (bouncy) bounce(sym, $urandom_range(6, 16));
        GPIO = 3'b000;
        step(12);
        if (q.size() < 3) q.push_back(sym);
        chk("press.err", err_total - e0, 0);
    endtask

    task automatic do_multi(input logic [2:0] pat);
        int e0;
        e0 = err_total;
        GPIO = pat;
        step(20);
        GPIO = 3'b000;
        step(12);
        chk("multi.err", err_total - e0, (q.size() < 3) ? 1 : 0);
    endtask

    task automatic do_ack();
        code_ack = 1'b1;
        step(1);
        code_ack = 1'b0;
        if (q.size() == 3) q.delete();
        check_model("ack");
    endtask

    initial begin
        int n;
        logic [2:0] mp[4];
        mp = '{3'b011, 3'b101, 3'b110, 3'b111};

        // reset state
        step(3);
        reset = 1'b0;
        q.delete();
        step(1);
        check_model("reset");
        chk("reset.err", entry_error, 0);

        // 1: latency and first capture
        GPIO = 3'b010;
        n = 0;
        while (num_inputs == 2'd0 && n < 40) begin
            step(1);
            n++;
        end
        chk("t1.latency_in_range", (n >= D + 2 && n <= D + 4) ? 1 : 0, 1);
        if (n < 20) step(20 - n);
        GPIO = 3'b000;
        step(12);
        q.push_back(1);
        check_model("t1");

        // 2: full code, hold, ack
        do_reset();
        do_press(2, 0, 15);
        do_press(0, 0, 15);
        do_press(1, 0, 15);
        check_model("t2");
        step(50);
        check_model("t2.hold");
        do_ack();

        // 3: pure bounce never debounces
        n = err_total;
        GPIO = 3'b000;
        for (int i = 0; i < 15; i++) begin
            GPIO[0] = ~GPIO[0];
            step(2);
        end
        GPIO = 3'b000;
        step(12);
        check_model("t3");
        chk("t3.err", err_total - n, 0);

        // 4: multi press then recovery
        do_multi(3'b011);
        check_model("t4");
        do_press(1, 0, 15);
        check_model("t4.after");

        // 5: long hold and ignored presses in S_DONE
        do_reset();
        do_press(2, 0, 200);
        check_model("t5.hold");
        do_press(0, 1, 15);
        do_press(1, 1, 15);
        do_press(2, 0, 15);
        do_multi(3'b110);
        check_model("t5.done");
        do_ack();

        // 6: reset right after b captured, button held through reset
        do_reset();
        do_press(0, 0, 15);
        GPIO = 3'b100;
        n = 0;
        while (num_inputs != 2'd2 && n < 40) begin
            step(1);
            n++;
        end
        chk("t6.b_captured", num_inputs, 2);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        q.delete();
        check_model("t6.reset");
        step(12);
        q.push_back(2);
        check_model("t6.held");
        GPIO = 3'b000;
        step(12);
        check_model("t6.release");

        // randomized action sequence
        do_reset();
        for (int i = 0; i < 60; i++) begin
            int act;
            act = $urandom_range(0, 9);
            if (act <= 5)      do_press($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(12, 30));
            else if (act == 6) do_multi(mp[$urandom_range(0, 3)]);
            else if (act <= 8) do_ack();
            else begin
                bounce($urandom_range(0, 2), $urandom_range(6, 20));
                GPIO = 3'b000;
                step(12);
            end
            check_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
